keypad_digit_collector: RTL and testbench

//  Scans a 4x4 matrix keypad, debounces it and assembles the pressed digits into a senhaPac_t packet.

---
 rtl/tipos_pkg.sv | 71 +++++++
 rtl/keypad_digit_collector_scanner.sv | 138 +++++++++++++
 rtl/keypad_digit_collector.sv | 161 ++++++++++++++++
 tb/tb_keypad_digit_collector.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tipos_pkg.sv
// Shared keypad/lock types: password packet, key codes and packet nibble constants.
package Tipos;

  localparam int NUM_DIGITS = 20;

  // digits[0] holds the most recently entered digit
  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] digits;
  } senhaPac_t;

  typedef enum logic [3:0] {
    K0      = 4'd0,
    K1      = 4'd1,
    K2      = 4'd2,
    K3      = 4'd3,
    K4      = 4'd4,
    K5      = 4'd5,
    K6      = 4'd6,
    K7      = 4'd7,
    K8      = 4'd8,
    K9      = 4'd9,
    KSTAR   = 4'd10,
    KHASH   = 4'd11,
    KLETTER = 4'd12
  } keypad_key_t;

  localparam logic [3:0] DIG_EMPTY  = 4'hF;
  localparam logic [3:0] CMD_EXIT   = 4'hB;
  localparam logic [3:0] CMD_CANCEL = 4'hE;

  localparam senhaPac_t PAC_EMPTY = {NUM_DIGITS{DIG_EMPTY}};

  function automatic senhaPac_t fill_pac(input logic [3:0] nib);
    senhaPac_t p;
    p = {NUM_DIGITS{nib}};
    return p;
  endfunction

  // Index of the lowest active-low bit; lowest row wins when several are low.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Row r0..r3: "1 2 3 A", "4 5 6 B", "7 8 9 C", "* 0 # D"
  function automatic keypad_key_t decode_key(input logic [1:0] row, input logic [1:0] colx);
    keypad_key_t k;
    k = KLETTER;
    case ({row, colx})
      4'b00_00: k = K1;
      4'b00_01: k = K2;
      4'b00_10: k = K3;
      4'b01_00: k = K4;
      4'b01_01: k = K5;
      4'b01_10: k = K6;
      4'b10_00: k = K7;
      4'b10_01: k = K8;
      4'b10_10: k = K9;
      4'b11_00: k = KSTAR;
      4'b11_01: k = K0;
      4'b11_10: k = KHASH;
      default:  k = KLETTER;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_digit_collector_scanner.sv
// Matrix keypad scanner: column rotation, press/release debounce and hold timing.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// SCAN     | rotating the driven column, waiting for any row to go low
// DEBOUNCE | column frozen, row pattern must stay identical to accept
// PRESSED  | key accepted, counting how long it stays down
// RELEASE  | rows all high, must stay high long enough to count as released
module keypad_scanner
  import Tipos::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  lin,
  output logic [3:0]  col,
  output keypad_key_t key_code,
  output logic        key_press,
  output logic        key_release,
  output logic        key_hold
);

  localparam int SCAN_W = $clog2(SCAN_CYCLES + 1);
  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} scan_state_t;

  scan_state_t       state_q;
  logic [3:0]        col_q;
  logic [3:0]        lin_q;
  logic [SCAN_W-1:0] scan_cnt_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  keypad_key_t       key_q;
  logic              press_q;
  logic              release_q;
  logic              hold_q;

  // Scanner FSM with registered column drive and one-cycle key strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SCAN;
      col_q      <= 4'b1110;
      lin_q      <= 4'hF;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      key_q      <= KLETTER;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else if (!enable) begin
      state_q    <= SCAN;
      col_q      <= 4'b1110;
      lin_q      <= 4'hF;
      scan_cnt_q <= '0;
      deb_cnt_q  <= '0;
      hold_cnt_q <= '0;
      key_q      <= KLETTER;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      case (state_q)
        SCAN: begin
          if (lin != 4'hF) begin
            lin_q      <= lin;
            deb_cnt_q  <= '0;
            scan_cnt_q <= '0;
            state_q    <= DEBOUNCE;
          end else if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_q <= '0;
            col_q      <= {col_q[2:0], col_q[3]};
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (lin != lin_q) begin
            deb_cnt_q <= '0;
            state_q   <= SCAN;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            key_q      <= decode_key(low_index(lin_q), low_index(col_q));
            press_q    <= 1'b1;
            state_q    <= PRESSED;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          if (lin == 4'hF) begin
            deb_cnt_q <= '0;
            state_q   <= RELEASE;
          end else if (hold_cnt_q != HOLD_MAX) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
            if (hold_cnt_q == HOLD_LAST) hold_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (lin != 4'hF) begin
            deb_cnt_q <= '0;
          end else if (deb_cnt_q == DEB_LAST) begin
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            scan_cnt_q <= '0;
            release_q  <= 1'b1;
            state_q    <= SCAN;
          end else begin
            deb_cnt_q <= deb_cnt_q + 1'b1;
          end
        end
        default: state_q <= SCAN;
      endcase
    end
  end

  assign col         = col_q;
  assign key_code    = key_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_hold    = hold_q;

endmodule

// File: rtl/keypad_digit_collector.sv
// Keypad digit collector: assembles debounced digits into a senhaPac_t packet and
// issues submit / skip / exit / cancel pulses on digitos_valid.
// Optional feature: define KEYPAD_BEEP_EN to get a key_beep pulse after each accepted key.
module keypad_digit_collector
  import Tipos::*;
#(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int HOLD_CYCLES     = 2000000,
  parameter int TIMEOUT_CYCLES  = 5000000,
  parameter int BEEP_CYCLES     = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic [3:0] col,
  input  logic [3:0] lin,
  output senhaPac_t  digitos_value,
  output logic       digitos_valid,
  output logic       key_beep
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  keypad_key_t key_code;
  logic        key_press;
  logic        key_release;
  logic        key_hold;

  keypad_scanner #(
    .SCAN_CYCLES    (SCAN_CYCLES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_scanner (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .lin        (lin),
    .col        (col),
    .key_code   (key_code),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  senhaPac_t       pac_q, pac_d;
  senhaPac_t       value_q, value_d;
  senhaPac_t       cmd;
  logic            valid_q, valid_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            hold_fired_q, hold_fired_d;
  logic            key_evt;

  // Letters never touch the buffer, the timeout or the beep.
  assign key_evt = (key_press | key_release | key_hold) && (key_code != KLETTER);

  // Assembler: buffer update, command selection and timeout; key events take priority
  always_comb begin
    pac_d        = pac_q;
    cmd          = PAC_EMPTY;
    valid_d      = 1'b0;
    to_cnt_d     = to_cnt_q;
    hold_fired_d = hold_fired_q;

    if (key_press && key_code != KLETTER) begin
      hold_fired_d = 1'b0;
      if (key_code == KSTAR) begin
        pac_d = PAC_EMPTY;
      end else if (key_code <= K9) begin
        pac_d.digits = {pac_q.digits[NUM_DIGITS-2:0], 4'(key_code)};
      end
    end else if (key_hold && key_code == KHASH) begin
      valid_d      = 1'b1;
      cmd          = fill_pac(CMD_EXIT);
      pac_d        = PAC_EMPTY;
      hold_fired_d = 1'b1;
    end else if (key_release && key_code == KHASH && !hold_fired_q) begin
      // An empty buffer is already all-F, so skip and submit share this path.
      valid_d = 1'b1;
      cmd     = pac_q;
      pac_d   = PAC_EMPTY;
    end

    if (key_evt || pac_q == PAC_EMPTY) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      valid_d  = 1'b1;
      cmd      = fill_pac(CMD_CANCEL);
      pac_d    = PAC_EMPTY;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    value_d = valid_d ? cmd : pac_d;
  end

  // Assembler state and registered packet outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pac_q        <= PAC_EMPTY;
      value_q      <= PAC_EMPTY;
      valid_q      <= 1'b0;
      to_cnt_q     <= '0;
      hold_fired_q <= 1'b0;
    end else if (!enable) begin
      pac_q        <= PAC_EMPTY;
      value_q      <= PAC_EMPTY;
      valid_q      <= 1'b0;
      to_cnt_q     <= '0;
      hold_fired_q <= 1'b0;
    end else begin
      pac_q        <= pac_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      to_cnt_q     <= to_cnt_d;
      hold_fired_q <= hold_fired_d;
    end
  end

  assign digitos_value = value_q;
  assign digitos_valid = valid_q;

`ifdef KEYPAD_BEEP_EN
  localparam int BEEP_W = $clog2(BEEP_CYCLES + 1);

  logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;
  logic              beep_q;

  // Beep length counter, reloaded by every accepted non-letter key
  always_comb begin
    beep_cnt_d = beep_cnt_q;
    if (key_press && key_code != KLETTER) begin
      beep_cnt_d = BEEP_W'(BEEP_CYCLES);
    end else if (beep_cnt_q != '0) begin
      beep_cnt_d = beep_cnt_q - 1'b1;
    end
  end

  // Registered beep request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else if (!enable) begin
      beep_cnt_q <= '0;
      beep_q     <= 1'b0;
    end else begin
      beep_cnt_q <= beep_cnt_d;
      beep_q     <= (beep_cnt_d != '0);
    end
  end

  assign key_beep = beep_q;
`else
  // Always 0; BEEP_CYCLES is referenced so both builds share one parameter list.
  assign key_beep = (BEEP_CYCLES < 0);
`endif

endmodule

// File: tb/tb_keypad_digit_collector.sv
`timescale 1ns/1ps
module tb_keypad_digit_collector;
  import Tipos::*;

  localparam logic [79:0] ALL_F = {20{4'hF}};
  localparam logic [79:0] ALL_B = {20{4'hB}};
  localparam logic [79:0] ALL_E = {20{4'hE}};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] col;
  logic [3:0] lin;
  senhaPac_t  dv;
  logic       dvalid;
  logic       beep;

  logic       key_down = 1'b0;
  logic [1:0] key_r = 2'd0;
  logic [1:0] key_c = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] lin_force = 4'hF;

  int tests_run = 0;
  int tests_failed = 0;

  int pulse_cnt = 0;
  int multi_err = 0;
  int beep_total = 0;
  int beep_run = 0;
  int last_beep_len = 0;
  logic [79:0] last_pulse = '0;
  logic [79:0] after_pulse = '0;
  logic prev_valid = 1'b0;

  always #5 clk = ~clk;

  keypad_digit_collector #(
    .SCAN_CYCLES    (4),
    .DEBOUNCE_CYCLES(8),
    .HOLD_CYCLES    (64),
    .TIMEOUT_CYCLES (200),
    .BEEP_CYCLES    (5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .col          (col),
    .lin          (lin),
    .digitos_value(dv),
    .digitos_valid(dvalid),
    .key_beep     (beep)
  );

  // keypad matrix: a held key pulls its row low only while its column is driven
  always_comb begin
    lin = 4'hF;
    if (force_en) lin = lin_force;
    else if (key_down && col[key_c] == 1'b0) lin[key_r] = 1'b0;
  end

  // pulse and beep monitor
  always @(negedge clk) begin
    if (prev_valid) after_pulse = dv;
    if (dvalid) begin
      pulse_cnt++;
      last_pulse = dv;
      if (prev_valid) multi_err++;
    end
    prev_valid = dvalid;
    if (beep) begin
      beep_total++;
      beep_run++;
    end else if (beep_run != 0) begin
      last_beep_len = beep_run;
      beep_run = 0;
    end
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic tap(input logic [1:0] r, input logic [1:0] c, input int hold);
    key_r = r;
    key_c = c;
    key_down = 1'b1;
    tick(hold);
    key_down = 1'b0;
    tick(20);
  endtask

  task automatic digit(input int d);
    if (d == 0) tap(2'd3, 2'd1, 40);
    else tap(2'((d - 1) / 3), 2'((d - 1) % 3), 40);
  endtask

  task automatic wait_pulse(input int base, input int max, input string tag);
    int n;
    n = 0;
    while (pulse_cnt == base && n < max) begin
      tick(1);
      n++;
    end
    check(tag, (pulse_cnt != base), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0;
    int bt;
    tick(3);
    check("rst_col", col, 4'b1110);
    check("rst_value", dv, ALL_F);
    check("rst_valid", dvalid, 0);
    check("rst_beep", beep, 0);
    rst = 1'b1;
    tick(2);

    // 1: digits 1,2,3 then short '#'
    p0 = pulse_cnt;
    digit(1); digit(2); digit(3);
    check("t1_live", dv, {{17{4'hF}}, 12'h123});
    check("t1_nopulse", pulse_cnt - p0, 0);
    tap(2'd3, 2'd2, 40);
    check("t1_pulses", pulse_cnt - p0, 1);
    check("t1_packet", last_pulse, {{17{4'hF}}, 12'h123});
    check("t1_after", after_pulse, ALL_F);
    check("t1_cleared", dv, ALL_F);

    // 2: short '#' with empty buffer
    p0 = pulse_cnt;
    tap(2'd3, 2'd2, 40);
    check("t2_pulses", pulse_cnt - p0, 1);
    check("t2_skip", last_pulse, ALL_F);

    // 3: long '#' hold
    digit(5);
    check("t3_live", dv, {{19{4'hF}}, 4'h5});
    p0 = pulse_cnt;
    tap(2'd3, 2'd2, 110);
    check("t3_pulses", pulse_cnt - p0, 1);
    check("t3_exit", last_pulse, ALL_B);
    check("t3_cleared", dv, ALL_F);

    // 4: timeout, then '*' clear
    digit(7);
    check("t4_live", dv, {{19{4'hF}}, 4'h7});
    p0 = pulse_cnt;
    wait_pulse(p0, 400, "t4_timeout_seen");
    check("t4_cancel", last_pulse, ALL_E);
    tick(2);
    check("t4_cleared", dv, ALL_F);
    p0 = pulse_cnt;
    digit(7);
    tap(2'd3, 2'd0, 40);
    check("t4_star", dv, ALL_F);
    check("t4_star_nopulse", pulse_cnt - p0, 0);

    // 5: 21 digits, oldest dropped; short glitch ignored
    p0 = pulse_cnt;
    for (int i = 0; i < 20; i++) digit(i % 10);
    digit(5);
    check("t5_overflow", dv, 80'h12345678901234567895);
    check("t5_nopulse", pulse_cnt - p0, 0);
    tap(2'd3, 2'd0, 40);
    digit(4);
    lin_force = 4'hE;
    force_en = 1'b1;
    tick(3);
    force_en = 1'b0;
    tick(30);
    check("t5_glitch", dv, {{19{4'hF}}, 4'h4});
    tap(2'd3, 2'd0, 40);

    // 6: reset mid-debounce with key still held
    digit(8);
    check("t6_live", dv, {{19{4'hF}}, 4'h8});
    lin_force = 4'hE;
    force_en = 1'b1;
    tick(3);
    rst = 1'b0;
    #1;
    check("t6_rst_col", col, 4'b1110);
    check("t6_rst_value", dv, ALL_F);
    check("t6_rst_valid", dvalid, 0);
    check("t6_rst_beep", beep, 0);
    tick(2);
    rst = 1'b1;
    tick(4);
    check("t6_not_yet", dv, ALL_F);
    tick(30);
    check("t6_redebounced", dv, {{19{4'hF}}, 4'h1});
`ifdef KEYPAD_BEEP_EN
    check("t6_beep_len", last_beep_len, 5);
`endif
    force_en = 1'b0;
    tick(20);
    tap(2'd3, 2'd0, 40);

    // letter key is ignored
    bt = beep_total;
    p0 = pulse_cnt;
    tap(2'd0, 2'd3, 40);
    check("letter_value", dv, ALL_F);
    check("letter_nopulse", pulse_cnt - p0, 0);
`ifdef KEYPAD_BEEP_EN
    check("letter_nobeep", beep_total - bt, 0);
`endif

    // enable low clears
    digit(9);
    check("en_live", dv, {{19{4'hF}}, 4'h9});
    enable = 1'b0;
    tick(1);
    check("en_value", dv, ALL_F);
    check("en_col", col, 4'b1110);
    enable = 1'b1;
    tick(5);

    check("single_cycle_valid", multi_err, 0);
`ifndef KEYPAD_BEEP_EN
    check("beep_tied_low", beep_total, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
